if_fetch_queue: RTL

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue_pkg.sv | 29 ++
 rtl/if_fetch_queue_sync_fifo.sv | 53 +++++
 rtl/if_fetch_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared cpu package: fetch FSM states, redirect select and NOP encoding.
package if_fetch_queue_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } fq_state_e;

   typedef enum logic [1:0] {
      RS_NONE   = 2'd0,
      RS_BRANCH = 2'd1,
      RS_FLUSH  = 2'd2
   } redir_sel_e;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   // Flush outranks a taken branch.
   function automatic redir_sel_e redir_sel(input logic flush,
                                            input logic br);
      if (flush)
         return RS_FLUSH;
      else if (br)
         return RS_BRANCH;
      else
         return RS_NONE;
   endfunction

endpackage

// File: rtl/if_fetch_queue_sync_fifo.sv
// Synchronous FIFO with occupancy count and clear.
// DEPTH must be a power of 2.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_clr,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [CNT_W-1:0] r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_cnt == CNT_W'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;
   assign o_data  = r_mem[r_rd];

   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop)
            r_rd <= r_rd + 1'b1;
         r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues fetches, tags responses, drains on redirect.
// Define IF_FETCH_BYPASS_EN to present a response to decode in its arrival cycle.
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int                ADDR_W   = 30,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              o_mem_req,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic              i_mem_gnt,
   input  logic              i_mem_rvalid,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_flush,
   input  logic [ADDR_W-1:0] i_new_pc,
   input  logic              i_br_taken,
   input  logic [ADDR_W-1:0] i_br_addr,
   output logic              o_if_valid,
   output logic [ADDR_W-1:0] o_if_pc,
   output logic [DATA_W-1:0] o_if_insn,
   input  logic              i_id_ready
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int SUM_W = CNT_W + 1;

   fq_state_e         r_state;
   fq_state_e         w_state_nxt;
   redir_sel_e        w_sel;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_last_pc;
   logic [DATA_W-1:0] r_last_insn;
   logic [CNT_W-1:0]  r_drop;
   logic [ADDR_W-1:0] w_target;
   logic              w_redir;
   logic              w_gnt;
   logic              w_rsp;
   logic              w_drop_rsp;
   logic              w_keep;
   logic              w_byp;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_tag_pc;
   logic              w_tag_full;
   logic              w_tag_empty;
   logic [CNT_W-1:0]  w_out;
   logic [ADDR_W-1:0] w_head_pc;
   logic [DATA_W-1:0] w_head_insn;
   logic              w_q_full;
   logic              w_q_empty;
   logic [CNT_W-1:0]  w_fill;
   logic [CNT_W-1:0]  w_fill_nxt;
   logic [CNT_W-1:0]  w_out_nxt;
   logic [CNT_W-1:0]  w_drop_nxt;
   logic [SUM_W-1:0]  w_sum_nxt;
   logic [ADDR_W-1:0] w_if_pc;
   logic [DATA_W-1:0] w_if_insn;

   assign w_sel   = redir_sel(i_flush, i_br_taken);
   assign w_redir = (w_sel != RS_NONE);

   always_comb begin
      w_target = r_fetch_pc;
      unique case (w_sel)
         RS_FLUSH:  w_target = i_new_pc;
         RS_BRANCH: w_target = i_br_addr;
         default:   w_target = r_fetch_pc;
      endcase
   end

   assign o_mem_req  = (r_state == ST_FETCH) & ~w_redir
                     & ~w_tag_full & ~w_q_full;
   assign o_mem_addr = r_fetch_pc;
   assign w_gnt      = o_mem_req & i_mem_gnt;

   // Every response pops its tag, dropped or not, to keep tags aligned.
   assign w_rsp      = i_mem_rvalid & ~w_tag_empty;
   assign w_drop_rsp = w_rsp & (w_redir | (r_drop != '0));
   assign w_keep     = w_rsp & ~w_drop_rsp;

`ifdef IF_FETCH_BYPASS_EN
   assign w_byp  = w_keep & w_q_empty;
   assign w_push = w_keep & ~(w_byp & i_id_ready);
`else
   assign w_byp  = 1'b0;
   assign w_push = w_keep;
`endif

   assign w_pop = i_id_ready & ~w_q_empty & ~w_redir;

   sync_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (1'b0),
      .i_push  (w_gnt),
      .i_data  (r_fetch_pc),
      .i_pop   (w_rsp),
      .o_data  (w_tag_pc),
      .o_full  (w_tag_full),
      .o_empty (w_tag_empty),
      .o_count (w_out)
   );

   sync_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_insn_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_redir),
      .i_push  (w_push),
      .i_data  ({w_tag_pc, i_mem_rdata}),
      .i_pop   (w_pop),
      .o_data  ({w_head_pc, w_head_insn}),
      .o_full  (w_q_full),
      .o_empty (w_q_empty),
      .o_count (w_fill)
   );

   always_comb begin
      w_if_pc   = r_last_pc;
      w_if_insn = r_last_insn;
      if (!w_q_empty) begin
         w_if_pc   = w_head_pc;
         w_if_insn = w_head_insn;
      end else if (w_byp) begin
         w_if_pc   = w_tag_pc;
         w_if_insn = i_mem_rdata;
      end
   end

   assign o_if_valid = ~w_q_empty | w_byp;
   assign o_if_pc    = w_if_pc;
   assign o_if_insn  = w_if_insn;

   always_comb begin
      w_out_nxt  = w_out + CNT_W'(w_gnt) - CNT_W'(w_rsp);
      w_fill_nxt = w_redir ? '0
                 : w_fill + CNT_W'(w_push) - CNT_W'(w_pop);
      // Everything still in flight after a redirect is stale.
      w_drop_nxt = w_redir ? w_out - CNT_W'(w_rsp)
                 : r_drop - CNT_W'(w_drop_rsp);
      w_sum_nxt  = {1'b0, w_fill_nxt} + {1'b0, w_out_nxt};
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_redir) begin
         w_state_nxt = (w_out_nxt != '0) ? ST_DRAIN : ST_FETCH;
      end else begin
         unique case (r_state)
            ST_FETCH:
               if (w_sum_nxt == SUM_W'(DEPTH))
                  w_state_nxt = ST_HALT;
            ST_HALT:
               if (w_sum_nxt < SUM_W'(DEPTH))
                  w_state_nxt = ST_FETCH;
            ST_DRAIN:
               if (w_drop_nxt == '0)
                  w_state_nxt = ST_FETCH;
            default:
               w_state_nxt = ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_FETCH;
         r_fetch_pc  <= RESET_PC;
         r_drop      <= '0;
         r_last_pc   <= RESET_PC;
         r_last_insn <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_drop      <= w_drop_nxt;
         r_last_pc   <= w_if_pc;
         r_last_insn <= w_if_insn;
         if (w_redir)
            r_fetch_pc <= w_target;
         else if (w_gnt)
            r_fetch_pc <= r_fetch_pc + 1'b1;
      end
   end

endmodule
